// File: rtl/legendre_mult_pipe.sv
`timescale 1ns/1ps
// legendre_mult_pipe
// Pipelined multiplier for the Legendre segment-fit datapath. It forms the full
// DIN0_WIDTH x DIN1_WIDTH product, optionally rounds it, right-shifts it, and then
// saturates or wraps it into DOUT_WIDTH bits. Each register stage has its own valid
// bit, so an empty stage can fill while the stages after it are stalled.
//
// Stage contents:
//   stage 1          registered operands, or the final result when NUM_STAGE = 1
//   stages 2..N-1    full product, passed down the pipe
//   stage N          dout / ovf
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous reset, active-high
//   in_valid   in   din0/din1 are valid
//   in_ready   out  block accepts a beat this cycle
//   din0       in   multiplicand, DIN0_WIDTH bits
//   din1       in   multiplier, DIN1_WIDTH bits
//   out_valid  out  dout/ovf are valid
//   out_ready  in   downstream accepts a beat
//   dout       out  scaled product, DOUT_WIDTH bits
//   ovf        out  the scaled product did not fit the DOUT range
//   ovf_cnt    out  number of delivered beats with ovf=1; holds at 0xFFFF
module legendre_mult_pipe #(
   parameter int DIN0_WIDTH = 26,
   parameter int DIN1_WIDTH = 18,
   parameter int DOUT_WIDTH = 32,
   parameter int NUM_STAGE  = 3,
   parameter int SIGNED     = 0,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SATURATE   = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf,
   output logic [15:0]           ovf_cnt
);

   localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
   localparam int N  = NUM_STAGE;

   // Rounding constant 2^(SHIFT-1); the sum is kept one bit wider than the product.
   localparam logic [PW:0] RND = (ROUND != 0 && SHIFT > 0) ?
                                 ((PW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic [DOUT_WIDTH-1:0] SMIN = DOUT_WIDTH'(1) << (DOUT_WIDTH - 1);
   localparam logic [DOUT_WIDTH-1:0] SMAX = ~SMIN;

   logic [N:1]            r_v;
   logic [N:1]            w_rdy;
   logic [N:1]            w_vin;
   logic [PW-1:0]         w_p_last;
   logic [DOUT_WIDTH-1:0] r_dout;
   logic                  r_ovf;
   logic [15:0]           r_ovf_cnt;

   // Full-width product: the operands are extended to PW bits first, so the low PW bits
   // of the product are exact in both signed and unsigned modes.
   function automatic logic [PW-1:0] f_mul(input logic [DIN0_WIDTH-1:0] a,
                                           input logic [DIN1_WIDTH-1:0] b);
      logic          l_ea;
      logic          l_eb;
      logic [PW-1:0] l_a;
      logic [PW-1:0] l_b;
      l_ea = (SIGNED != 0) ? a[DIN0_WIDTH-1] : 1'b0;
      l_eb = (SIGNED != 0) ? b[DIN1_WIDTH-1] : 1'b0;
      l_a  = {{(PW-DIN0_WIDTH){l_ea}}, a};
      l_b  = {{(PW-DIN1_WIDTH){l_eb}}, b};
      return l_a * l_b;
   endfunction

   // Round, shift and range-limit. Returns {ovf, dout}.
   function automatic logic [DOUT_WIDTH:0] f_scale(input logic [PW-1:0] p);
      logic [PW:0]              l_sum;
      logic [PW:0]              l_res;
      logic [PW-DOUT_WIDTH+1:0] l_hi;
      logic                     l_ovf;
      logic [DOUT_WIDTH-1:0]    l_dout;
      l_sum = {((SIGNED != 0) ? p[PW-1] : 1'b0), p} + RND;
      if (SIGNED != 0) l_res = $signed(l_sum) >>> SHIFT;
      else             l_res = l_sum >> SHIFT;
      // Signed: every bit from the DOUT sign bit upward must agree with it.
      // Unsigned: everything above the DOUT MSB must be zero.
      l_hi = l_res[PW:DOUT_WIDTH-1];
      if (SIGNED != 0) l_ovf = (l_hi != '0) && (l_hi != '1);
      else             l_ovf = (l_hi[PW-DOUT_WIDTH+1:1] != '0);
      l_dout = l_res[DOUT_WIDTH-1:0];
      if (l_ovf && SATURATE != 0) begin
         if (SIGNED != 0) l_dout = l_res[PW] ? SMIN : SMAX;
         else             l_dout = '1;
      end
      return {l_ovf, l_dout};
   endfunction

   // A stage may load when it is empty or when the stage after it can take its beat.
   always_comb begin : p_rdy
      logic l_rdy;
      l_rdy = out_ready;
      w_rdy = '0;
      for (int i = N; i >= 1; i--) begin
         l_rdy    = ~r_v[i] | l_rdy;
         w_rdy[i] = l_rdy;
      end
   end

   always_comb begin
      w_vin    = '0;
      w_vin[1] = in_valid;
      for (int i = 2; i <= N; i++) w_vin[i] = r_v[i-1];
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_v <= '0;
      end else begin
         for (int i = 1; i <= N; i++) begin
            if (w_rdy[i]) r_v[i] <= w_vin[i];
         end
      end
   end

   generate
      if (N == 1) begin : g_n1
         assign w_p_last = f_mul(din0, din1);
      end else begin : g_nx
         logic [DIN0_WIDTH-1:0] r_a;
         logic [DIN1_WIDTH-1:0] r_b;

         always_ff @(posedge ap_clk) begin
            if (!ap_rst && w_rdy[1] && in_valid) begin
               r_a <= din0;
               r_b <= din1;
            end
         end

         if (N == 2) begin : g_n2
            assign w_p_last = f_mul(r_a, r_b);
         end else begin : g_n3
            logic [PW-1:0] r_p [2:N-1];

            always_ff @(posedge ap_clk) begin
               if (!ap_rst && w_rdy[2] && w_vin[2]) r_p[2] <= f_mul(r_a, r_b);
               for (int k = 3; k <= N - 1; k++) begin
                  if (!ap_rst && w_rdy[k] && w_vin[k]) r_p[k] <= r_p[k-1];
               end
            end

            assign w_p_last = r_p[N-1];
         end
      end
   endgenerate

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_dout <= '0;
         r_ovf  <= 1'b0;
      end else if (w_rdy[N] && w_vin[N]) begin
         {r_ovf, r_dout} <= f_scale(w_p_last);
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_ovf_cnt <= '0;
      end else if (r_v[N] && out_ready && r_ovf && r_ovf_cnt != 16'hFFFF) begin
         r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
   end

   assign in_ready  = w_rdy[1] & ~ap_rst;
   assign out_valid = r_v[N];
   assign dout      = r_dout;
   assign ovf       = r_ovf;
   assign ovf_cnt   = r_ovf_cnt;

endmodule
